reduce_child_tagger: RTL and testbench

//  Producer side of the reduction FIFO. Accepts raw 82-bit collective flits and tags each reduction flit with the

---
 rtl/reduce_child_tagger_pkg.sv | 48 ++++
 rtl/reduce_ctx_table.sv | 78 +++++++
 rtl/reduce_child_tagger.sv | 109 ++++++++++
 tb/tb_reduce_child_tagger.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reduce_child_tagger_pkg.sv
// rtl/reduce_child_tagger_pkg.sv - flit field map, reduction op codes and context entry type
package reduce_child_tagger_pkg;

    localparam int LgNumProcs    = 3;
    localparam int FlitW         = 82;
    localparam int PayloadPos    = 0;
    localparam int PayloadWidth  = 32;
    localparam int OpPos         = 32;
    localparam int OpWidth       = 4;
    localparam int AlgPos        = 36;
    localparam int AlgWidth      = 2;
    localparam int TagPos        = 38;
    localparam int TagWidth      = 8;
    localparam int CtxPos        = 46;
    localparam int CtxWidth      = 8;
    localparam int RankPos       = 54;
    localparam int RankWidth     = 9;
    localparam int SrcPos        = 63;
    localparam int SrcWidth      = 9;
    localparam int DstPos        = 72;
    localparam int DstWidth      = 9;
    localparam int ValidBitPos   = 81;
    localparam int ChildrenPos   = 82;
    localparam int ChildrenWidth = LgNumProcs;
    localparam int MaskWidth     = 1 << LgNumProcs;
    localparam int CntWidth      = LgNumProcs + 1;

    typedef enum logic [OpWidth-1:0] {
        ShortReduce    = 4'hC,
        ShortAllReduce = 4'hD,
        LargeReduce    = 4'hE,
        LargeAllReduce = 4'hF
    } red_op_e;

    typedef struct packed {
        logic                     en;
        logic [CtxWidth-1:0]      ctx;
        logic [ChildrenWidth-1:0] children;
        logic [CntWidth-1:0]      seen_cnt;
        logic [MaskWidth-1:0]     seen_mask;
    } ctx_entry_t;

    // Reduction ops share the 2'b11 prefix in the upper op bits.
    function automatic logic is_reduction(input logic [FlitW-1:0] f);
        return f[ValidBitPos] && (f[OpPos+OpWidth-1 -: 2] == 2'b11);
    endfunction

endpackage

// File: rtl/reduce_ctx_table.sv
// rtl/reduce_ctx_table.sv - associative context table with per-round child tracking
// Optional REDUCE_DUP_FILTER_EN: drop repeated child contributions within a round.
module reduce_ctx_table
    import reduce_child_tagger_pkg::*;
#(
    parameter int CtxTableSize = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_wr,
    input  logic [$clog2(CtxTableSize)-1:0] cfg_idx,
    input  logic [CtxWidth-1:0]             cfg_ctx,
    input  logic [ChildrenWidth-1:0]        cfg_children,
    input  logic                            cfg_en,
    input  logic [CtxWidth-1:0]             lk_ctx,
    input  logic [LgNumProcs-1:0]           lk_src_lo,
    input  logic                            lk_own,
    input  logic                            lk_commit,
    output logic                            lk_hit,
    output logic                            lk_dup,
    output logic [ChildrenWidth-1:0]        lk_children
);

    localparam int IdxW = $clog2(CtxTableSize);

    ctx_entry_t            entries [CtxTableSize];
    logic [IdxW-1:0]       hit_idx;
    ctx_entry_t            hit_e;
    logic [CntWidth-1:0]   cnt_next;
    logic                  round_close;
    logic                  upd;

    always_comb begin
        lk_hit  = 1'b0;
        hit_idx = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = CtxTableSize - 1; i >= 0; i--) begin
            if (entries[i].en && entries[i].ctx == lk_ctx) begin
                lk_hit  = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
        hit_e       = entries[hit_idx];
        lk_children = hit_e.children;
`ifdef REDUCE_DUP_FILTER_EN
        lk_dup      = lk_hit && !lk_own && hit_e.seen_mask[lk_src_lo];
`else
        lk_dup      = 1'b0;
`endif
        cnt_next    = hit_e.seen_cnt + CntWidth'(1);
        round_close = (cnt_next == CntWidth'(hit_e.children));
        upd         = lk_commit && lk_hit && !lk_dup && !lk_own && (hit_e.children != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CtxTableSize; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (upd) begin
                if (round_close) begin
                    entries[hit_idx].seen_cnt  <= '0;
                    entries[hit_idx].seen_mask <= '0;
                end else begin
                    entries[hit_idx].seen_cnt  <= cnt_next;
                    entries[hit_idx].seen_mask <= hit_e.seen_mask | (MaskWidth'(1) << lk_src_lo);
                end
            end
            // Placed last so a same-cycle configuration write overrides the round update.
            if (cfg_wr) begin
                entries[cfg_idx] <= '{en: cfg_en, ctx: cfg_ctx, children: cfg_children,
                                      seen_cnt: '0, seen_mask: '0};
            end
        end
    end

endmodule

// File: rtl/reduce_child_tagger.sv
// rtl/reduce_child_tagger.sv - tags reduction flits with children count and feeds the reduction FIFO
// Optional REDUCE_DUP_FILTER_EN enables duplicate-contribution dropping in reduce_ctx_table.
module reduce_child_tagger
    import reduce_child_tagger_pkg::*;
#(
    parameter int lg_numprocs  = LgNumProcs,
    parameter int FlitWidth    = FlitW,
    parameter int CtxTableSize = 4,
    parameter int fifo_lg_size = 12,
    parameter int AFullMargin  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FlitWidth-1:0]            in_flit,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            cfg_wr,
    input  logic [$clog2(CtxTableSize)-1:0] cfg_idx,
    input  logic [CtxWidth-1:0]             cfg_ctx,
    input  logic [lg_numprocs-1:0]          cfg_children,
    input  logic                            cfg_en,
    output logic [FlitWidth+lg_numprocs-1:0] fifo_din,
    output logic                            wr_en,
    input  logic                            buf_full,
    input  logic [fifo_lg_size:0]           fifo_counter,
    output logic                            miss_pulse,
    output logic                            dup_pulse
);

    localparam logic [fifo_lg_size:0] AFullThresh =
        (fifo_lg_size+1)'((1 << fifo_lg_size) - AFullMargin);

    logic                             s1_valid;
    logic [FlitWidth-1:0]             s1_flit;
    logic                             s2_valid;
    logic [FlitWidth+lg_numprocs-1:0] s2_data;

    logic                     s2_hold;
    logic                     s1_adv;
    logic                     accept;
    logic                     s1_red;
    logic                     s1_own;
    logic                     s1_fwd;
    logic                     lk_hit;
    logic                     lk_dup;
    logic [ChildrenWidth-1:0] lk_children;
    logic [ChildrenWidth-1:0] children_sel;

    assign s2_hold  = s2_valid && buf_full;
    assign s1_adv   = s1_valid && !s2_hold;
    assign in_ready = rst && !(s1_valid && s2_hold) && !(fifo_counter >= AFullThresh);
    assign accept   = in_valid && in_ready;

    assign s1_red = is_reduction(s1_flit);
    assign s1_own = (s1_flit[SrcPos +: SrcWidth] == s1_flit[RankPos +: RankWidth]);

    reduce_ctx_table #(
        .CtxTableSize (CtxTableSize)
    ) u_ctx_table (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_ctx      (cfg_ctx),
        .cfg_children (cfg_children),
        .cfg_en       (cfg_en),
        .lk_ctx       (s1_flit[CtxPos +: CtxWidth]),
        .lk_src_lo    (s1_flit[SrcPos +: LgNumProcs]),
        .lk_own       (s1_own),
        .lk_commit    (s1_adv && s1_red),
        .lk_hit       (lk_hit),
        .lk_dup       (lk_dup),
        .lk_children  (lk_children)
    );

    assign s1_fwd       = !s1_red || (lk_hit && !lk_dup);
    assign children_sel = s1_red ? lk_children : '0;
    assign miss_pulse   = s1_adv && s1_red && !lk_hit;
    assign dup_pulse    = s1_adv && s1_red && lk_hit && lk_dup;

    // Flits without the valid bit are consumed here and never occupy S1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_flit  <= '0;
        end else if (accept) begin
            s1_valid <= in_flit[ValidBitPos];
            s1_flit  <= in_flit;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (!s2_hold) begin
            s2_valid <= s1_adv && s1_fwd;
            if (s1_adv && s1_fwd) begin
                s2_data <= {children_sel, s1_flit};
            end
        end
    end

    assign wr_en    = s2_valid && !buf_full;
    assign fifo_din = s2_data;

endmodule

// File: tb/tb_reduce_child_tagger.sv
// tb/tb_reduce_child_tagger.sv - directed self-checking bench for reduce_child_tagger
module tb_reduce_child_tagger;
    import reduce_child_tagger_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [81:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_wr;
    logic [1:0]  cfg_idx;
    logic [7:0]  cfg_ctx;
    logic [2:0]  cfg_children;
    logic        cfg_en;
    logic [84:0] fifo_din;
    logic        wr_en;
    logic        buf_full;
    logic [12:0] fifo_counter;
    logic        miss_pulse;
    logic        dup_pulse;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reduce_child_tagger dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_ctx      (cfg_ctx),
        .cfg_children (cfg_children),
        .cfg_en       (cfg_en),
        .fifo_din     (fifo_din),
        .wr_en        (wr_en),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter),
        .miss_pulse   (miss_pulse),
        .dup_pulse    (dup_pulse)
    );

    task automatic check(input string tag, input logic [84:0] got, input logic [84:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [81:0] mk(input logic v, input logic [7:0] ctx, input logic [8:0] src,
                                       input logic [8:0] rank, input logic [3:0] op, input logic [31:0] pl);
        return {v, 9'h1A3, src, rank, ctx, 8'h5C, 2'b10, op, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] ctx, input logic [2:0] ch, input logic en);
        cfg_idx = idx; cfg_ctx = ctx; cfg_children = ch; cfg_en = en; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    // One flit through an empty pipeline: S1 observations, then the S2 write.
    task automatic xfer(input string tag, input logic [81:0] f, input logic exp_wr,
                        input logic exp_miss, input logic exp_dup, input logic [2:0] exp_ch);
        in_flit = f; in_valid = 1'b1;
        #1;
        check({tag, "_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        check({tag, "_miss"}, miss_pulse, exp_miss);
        check({tag, "_dup"}, dup_pulse, exp_dup);
        check({tag, "_early_wr"}, wr_en, 1'b0);
        tick();
        check({tag, "_wr"}, wr_en, exp_wr);
        if (exp_wr) check({tag, "_din"}, fifo_din, {exp_ch, f});
        check({tag, "_miss_clr"}, miss_pulse, 1'b0);
    endtask

    logic [81:0] fa, fb, fc, f1, f2;
    logic [84:0] got [3];
    int          nw;
    logic        acc;
    logic        filt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REDUCE_DUP_FILTER_EN
        filt = 1'b1;
`else
        filt = 1'b0;
`endif
        rst = 1'b0; in_flit = '0; in_valid = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_ctx = '0;
        cfg_children = '0; cfg_en = 1'b0; buf_full = 1'b0; fifo_counter = '0;
        tick(); tick();
        check("rst_ready", in_ready, 1'b0);
        check("rst_wr", wr_en, 1'b0);
        check("rst_din", fifo_din, 85'd0);
        check("rst_miss", miss_pulse, 1'b0);
        check("rst_dup", dup_pulse, 1'b0);
        rst = 1'b1;
        tick();

        // Basic tagging, unknown context, non-reduction and invalid flits
        cfg_write(2'd0, 8'h05, 3'd2, 1'b1);
        xfer("t1", mk(1'b1, 8'h05, 9'd1, 9'd0, ShortAllReduce, 32'hDEADBEEF), 1'b1, 1'b0, 1'b0, 3'd2);
        xfer("t2", mk(1'b1, 8'h09, 9'd1, 9'd0, ShortReduce, 32'h11111111), 1'b0, 1'b1, 1'b0, 3'd0);
        xfer("t2b", mk(1'b1, 8'h09, 9'd1, 9'd0, 4'h2, 32'h22222222), 1'b1, 1'b0, 1'b0, 3'd0);
        xfer("t2c", mk(1'b0, 8'h05, 9'd1, 9'd0, LargeReduce, 32'h33333333), 1'b0, 1'b0, 1'b0, 3'd0);

        // Back-pressure: S2 and S1 fill, the third flit waits
        fa = mk(1'b1, 8'h00, 9'd3, 9'd0, 4'h2, 32'hAAAA0001);
        fb = mk(1'b1, 8'h00, 9'd3, 9'd0, 4'h2, 32'hAAAA0002);
        fc = mk(1'b1, 8'h00, 9'd3, 9'd0, 4'h2, 32'hAAAA0003);
        buf_full = 1'b1;
        in_flit = fa; in_valid = 1'b1;
        tick();
        in_flit = fb;
        tick();
        in_flit = fc;
        #1;
        check("t3_ready_low", in_ready, 1'b0);
        check("t3_wr_low", wr_en, 1'b0);
        check("t3_din_hold", fifo_din, {3'd0, fa});
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_din_stable", fifo_din, {3'd0, fa});
            check("t3_ready_stall", in_ready, 1'b0);
        end
        buf_full = 1'b0;
        #1;
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            if (wr_en) begin
                if (nw < 3) got[nw] = fifo_din;
                nw++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            #1;
        end
        check("t3_nwrites", 85'(nw), 85'd3);
        check("t3_w0", got[0], {3'd0, fa});
        check("t3_w1", got[1], {3'd0, fb});
        check("t3_w2", got[2], {3'd0, fc});

        // Almost-full threshold
        fifo_counter = 13'd4092;
        #1;
        check("t4_afull", in_ready, 1'b0);
        fifo_counter = 13'd4091;
        #1;
        check("t4_below", in_ready, 1'b1);
        fifo_counter = 13'd0;
        tick();

        // Round tracking; entry 2 shadows ctx 7 but lowest index wins
        cfg_write(2'd1, 8'h07, 3'd2, 1'b1);
        cfg_write(2'd2, 8'h07, 3'd5, 1'b1);
        xfer("t5a", mk(1'b1, 8'h07, 9'd1, 9'd0, ShortReduce, 32'h50000001), 1'b1, 1'b0, 1'b0, 3'd2);
        xfer("t5b", mk(1'b1, 8'h07, 9'd1, 9'd0, ShortReduce, 32'h50000002), !filt, 1'b0, filt, 3'd2);
        xfer("t5c", mk(1'b1, 8'h07, 9'd2, 9'd0, ShortReduce, 32'h50000003), 1'b1, 1'b0, 1'b0, 3'd2);
        xfer("t5d", mk(1'b1, 8'h07, 9'd1, 9'd0, ShortReduce, 32'h50000004), 1'b1, 1'b0, 1'b0, 3'd2);
        xfer("t5own1", mk(1'b1, 8'h07, 9'd4, 9'd4, LargeAllReduce, 32'h50000005), 1'b1, 1'b0, 1'b0, 3'd2);
        xfer("t5own2", mk(1'b1, 8'h07, 9'd4, 9'd4, LargeAllReduce, 32'h50000006), 1'b1, 1'b0, 1'b0, 3'd2);
        cfg_write(2'd3, 8'h0A, 3'd0, 1'b1);
        xfer("t5leaf1", mk(1'b1, 8'h0A, 9'd1, 9'd0, ShortReduce, 32'h50000007), 1'b1, 1'b0, 1'b0, 3'd0);
        xfer("t5leaf2", mk(1'b1, 8'h0A, 9'd1, 9'd0, ShortReduce, 32'h50000008), 1'b1, 1'b0, 1'b0, 3'd0);

        // Reset with S1 and S2 occupied
        f1 = mk(1'b1, 8'h00, 9'd3, 9'd0, 4'h2, 32'h60000001);
        f2 = mk(1'b1, 8'h00, 9'd3, 9'd0, 4'h2, 32'h60000002);
        in_flit = f1; in_valid = 1'b1;
        tick();
        in_flit = f2;
        tick();
        in_valid = 1'b0;
        #1;
        check("t6_pre_wr", wr_en, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_wr_off", wr_en, 1'b0);
        check("t6_ready_off", in_ready, 1'b0);
        check("t6_din_clr", fifo_din, 85'd0);
        tick();
        check("t6_wr_held", wr_en, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_no_stale_wr", wr_en, 1'b0);
        xfer("t6m0", mk(1'b1, 8'h05, 9'd1, 9'd0, ShortReduce, 32'h60000003), 1'b0, 1'b1, 1'b0, 3'd0);
        xfer("t6m1", mk(1'b1, 8'h07, 9'd2, 9'd0, LargeReduce, 32'h60000004), 1'b0, 1'b1, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
